ps2_rx_fifo: RTL and testbench

Parametrised next-generation PS/2 device-to-host receiver for PicoSoC. It filters and synchronises the PS/2 clock/data lines, deserialises 11-bit frames, and checks parity and stop bits. Received bytes are buffered in a DEPTH-entry FIFO, and a frame-timeout watchdog resynchronises the receiver after a broken frame. A data register and a clear-on-read status register sit on the SoC register bus; a level interrupt reports a non-empty FIFO.

---
 rtl/ps2_rx_fifo.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a byte FIFO and a register-bus front end.
//   Filters and synchronises the PS/2 lines, deserialises 11-bit frames, checks parity
//   and stop bits, buffers good bytes in a DEPTH-entry FIFO and aborts stalled frames.
// Ports:
//   clk, resetn   system clock, synchronous active-low reset
//   ps2_clk       asynchronous PS/2 clock line
//   ps2_data      asynchronous PS/2 data line
//   reg_dat_re    data register read strobe (pops the FIFO head)
//   reg_dat_do    {24'b0, head byte}, all ones when the FIFO is empty
//   reg_dat_wait  always 0
//   reg_sta_re    status register read strobe (clears sticky error bits)
//   reg_sta_do    status word: {16'b0, count, 2'b0, tmo, ovf, frm, par, full, nonempty}
//   irq           high while the FIFO holds at least one byte
module ps2_rx_fifo #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned DEBOUNCE = 8,
   parameter int unsigned TIMEOUT  = 100000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        reg_dat_re,
   output logic [31:0] reg_dat_do,
   output logic        reg_dat_wait,
   input  logic        reg_sta_re,
   output logic [31:0] reg_sta_do,
   output logic        irq
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT);

   // Frame position, held in the bit counter
   localparam logic [3:0] CNT_IDLE   = 4'd0;
   localparam logic [3:0] CNT_LAST   = 4'd8;
   localparam logic [3:0] CNT_PARITY = 4'd9;

   // Synchronisers and clock filter
   logic                clk_s1, clk_s2;
   logic                dat_s1, dat_s2;
   logic [DEBOUNCE-1:0] hist;
   logic                filt, filt_q;
   logic                fall_c;

   // Frame deserialiser
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          push_c, set_par_c, set_frm_c, set_tmo_c;

   // FIFO
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, count;
   logic          empty_c, full_c, pop_c, wr_c, ovf_c;

   // Sticky error flags
   logic err_par, err_frm, err_ovf, err_tmo;

   // Two-stage synchronisers, then a DEBOUNCE-deep history that only flips the
   // filtered clock once every sample agrees.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
         hist   <= '1;
         filt   <= 1'b1;
         filt_q <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
         hist   <= {hist[DEBOUNCE-2:0], clk_s2};
         if (&hist) begin
            filt <= 1'b1;
         end else if (~|hist) begin
            filt <= 1'b0;
         end
         filt_q <= filt;
      end
   end

   assign fall_c = filt_q & ~filt;

   // Frame state register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q   <= CNT_IDLE;
         shift_q <= '0;
         par_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tmo_q   <= tmo_d;
      end
   end

   // Frame next-state: start, 8 data bits LSB first, odd parity, stop; watchdog
   // restarts on every falling edge and aborts a frame that stalls.
   always_comb begin
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tmo_d     = tmo_q;
      push_c    = 1'b0;
      set_par_c = 1'b0;
      set_frm_c = 1'b0;
      set_tmo_c = 1'b0;
      if (fall_c) begin
         tmo_d = '0;
         if (cnt_q == CNT_IDLE) begin
            if (!dat_s2) begin
               cnt_d   = 4'd1;
               shift_d = '0;
               par_d   = 1'b0;
            end
         end else if (cnt_q <= CNT_LAST) begin
            shift_d = {dat_s2, shift_q[7:1]};
            par_d   = par_q ^ dat_s2;
            cnt_d   = cnt_q + 4'd1;
         end else if (cnt_q == CNT_PARITY) begin
            par_d = par_q ^ dat_s2;
            cnt_d = cnt_q + 4'd1;
         end else begin
            // Stop bit: framing error masks a parity error
            cnt_d = CNT_IDLE;
            if (!dat_s2) begin
               set_frm_c = 1'b1;
            end else if (!par_q) begin
               set_par_c = 1'b1;
            end else begin
               push_c = 1'b1;
            end
         end
      end else if (cnt_q == CNT_IDLE) begin
         tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
         cnt_d     = CNT_IDLE;
         tmo_d     = '0;
         shift_d   = '0;
         set_tmo_c = 1'b1;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   // FIFO control: a pop frees a slot for a push arriving in the same cycle
   assign empty_c = (count == '0);
   assign full_c  = (count == PW'(DEPTH));
   assign pop_c   = reg_dat_re & ~empty_c;
   assign wr_c    = push_c & (~full_c | pop_c);
   assign ovf_c   = push_c & full_c & ~pop_c;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_c) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (wr_c && !pop_c) begin
            count <= count + PW'(1);
         end else if (!wr_c && pop_c) begin
            count <= count - PW'(1);
         end
      end
   end

   // Storage array, no reset needed: occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      if (resetn && wr_c) begin
         mem[wr_ptr[AW-1:0]] <= shift_q;
      end
   end

   // Sticky flags: a new set wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (!resetn) begin
         err_par <= 1'b0;
         err_frm <= 1'b0;
         err_ovf <= 1'b0;
         err_tmo <= 1'b0;
      end else begin
         err_par <= set_par_c | (err_par & ~reg_sta_re);
         err_frm <= set_frm_c | (err_frm & ~reg_sta_re);
         err_ovf <= ovf_c     | (err_ovf & ~reg_sta_re);
         err_tmo <= set_tmo_c | (err_tmo & ~reg_sta_re);
      end
   end

   // Register bus views, all decoded from registered state
   assign reg_dat_do   = empty_c ? 32'hFFFF_FFFF : {24'b0, mem[rd_ptr[AW-1:0]]};
   assign reg_dat_wait = 1'b0;
   assign reg_sta_do   = {16'b0, 8'(count), 2'b0, err_tmo, err_ovf, err_frm, err_par,
                          full_c, ~empty_c};
   assign irq          = ~empty_c;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed bench for ps2_rx_fifo (DEPTH=4, DEBOUNCE=4, TIMEOUT=1000).
//   Bit-bangs PS/2 frames with a 40-cycle half period and checks the register views.
module tb_ps2_rx_fifo;

   logic        clk;
   logic        resetn;
   logic        ps2_clk;
   logic        ps2_data;
   logic        reg_dat_re;
   logic [31:0] reg_dat_do;
   logic        reg_dat_wait;
   logic        reg_sta_re;
   logic [31:0] reg_sta_do;
   logic        irq;

   int total;
   int passes;
   int fails;

   ps2_rx_fifo #(
      .DEPTH    (4),
      .DEBOUNCE (4),
      .TIMEOUT  (1000)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .reg_dat_re   (reg_dat_re),
      .reg_dat_do   (reg_dat_do),
      .reg_dat_wait (reg_dat_wait),
      .reg_sta_re   (reg_sta_re),
      .reg_sta_do   (reg_sta_do),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and land 1 time unit after the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One PS/2 bit; with pop_at_fall the data strobe lands in the cycle the
   // filtered falling edge is seen (2 sync + 4 history + filter register stages)
   task automatic ps2_bit(input logic b, input bit pop_at_fall);
      ps2_data = b;
      tick(20);
      ps2_clk = 1'b0;
      if (pop_at_fall) begin
         tick(7);
         reg_dat_re = 1'b1;
         tick(1);
         reg_dat_re = 1'b0;
         tick(32);
      end else begin
         tick(40);
      end
      ps2_clk = 1'b1;
      tick(20);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input bit pop_at_stop);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         ps2_bit(d[i], 1'b0);
      end
      ps2_bit(par, 1'b0);
      ps2_bit(stop, pop_at_stop);
      ps2_data = 1'b1;
      tick(10);
   endtask

   task automatic send_good(input logic [7:0] d);
      send_frame(d, ~^d, 1'b1, 1'b0);
   endtask

   // Check the head, then pop it
   task automatic pop_check(input string tag, input logic [31:0] exp);
      check(tag, reg_dat_do, exp);
      reg_dat_re = 1'b1;
      tick(1);
      reg_dat_re = 1'b0;
   endtask

   // Read the status word (pre-clear value), clearing the sticky bits
   task automatic sta_read(input string tag, input logic [31:0] exp);
      reg_sta_re = 1'b1;
      check(tag, reg_sta_do, exp);
      tick(1);
      reg_sta_re = 1'b0;
   endtask

   initial begin
      total      = 0;
      passes     = 0;
      fails      = 0;
      resetn     = 1'b0;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      reg_dat_re = 1'b0;
      reg_sta_re = 1'b0;
      tick(5);
      resetn = 1'b1;
      tick(5);

      // Reset state
      check("rst_dat", reg_dat_do, 32'hFFFF_FFFF);
      check("rst_sta", reg_sta_do, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("dat_wait", 32'(reg_dat_wait), 32'h0);

      // Good byte 0x1C (parity 0)
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      check("b1c_irq", 32'(irq), 32'h1);
      check("b1c_dat", reg_dat_do, 32'h0000_001C);
      check("b1c_sta", reg_sta_do, 32'h0000_0101);
      pop_check("b1c_pop", 32'h0000_001C);
      check("b1c_empty", reg_dat_do, 32'hFFFF_FFFF);
      check("b1c_irq0", 32'(irq), 32'h0);

      // Parity error
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      check("par_dat", reg_dat_do, 32'hFFFF_FFFF);
      sta_read("par_sta", 32'h0000_0004);
      sta_read("par_clr", 32'h0000_0000);

      // Framing error (parity correct, stop 0)
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      check("frm_dat", reg_dat_do, 32'hFFFF_FFFF);
      sta_read("frm_sta", 32'h0000_0008);

      // Overflow: five bytes into four entries
      for (int i = 1; i <= 5; i++) begin
         send_good(8'(i));
      end
      check("ovf_sta", reg_sta_do, 32'h0000_0413);
      check("ovf_irq", 32'(irq), 32'h1);
      pop_check("ovf_pop1", 32'h0000_0001);
      pop_check("ovf_pop2", 32'h0000_0002);
      pop_check("ovf_pop3", 32'h0000_0003);
      pop_check("ovf_pop4", 32'h0000_0004);
      check("ovf_empty", reg_dat_do, 32'hFFFF_FFFF);
      reg_dat_re = 1'b1;
      tick(1);
      reg_dat_re = 1'b0;
      sta_read("ovf_after", 32'h0000_0010);

      // Push and pop in the same cycle while full
      for (int i = 1; i <= 4; i++) begin
         send_good(8'(i));
      end
      check("pp_full", reg_sta_do, 32'h0000_0403);
      send_frame(8'h05, ~^8'h05, 1'b1, 1'b1);
      check("pp_sta", reg_sta_do, 32'h0000_0403);
      pop_check("pp_pop2", 32'h0000_0002);
      pop_check("pp_pop3", 32'h0000_0003);
      pop_check("pp_pop4", 32'h0000_0004);
      pop_check("pp_pop5", 32'h0000_0005);
      check("pp_empty", reg_sta_do, 32'h0000_0000);

      // Timeout: start plus three data bits, then clock held high
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_data = 1'b1;
      tick(1200);
      check("tmo_dat", reg_dat_do, 32'hFFFF_FFFF);
      sta_read("tmo_sta", 32'h0000_0020);
      send_good(8'hAA);
      check("tmo_next", reg_sta_do, 32'h0000_0101);
      pop_check("tmo_aa", 32'h0000_00AA);

      // Two-cycle clock glitch with data low must not start a frame
      ps2_data = 1'b0;
      tick(10);
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(30);
      ps2_data = 1'b1;
      tick(20);
      check("glitch_sta", reg_sta_do, 32'h0000_0000);
      send_good(8'h5A);
      check("glitch_dat", reg_dat_do, 32'h0000_005A);
      check("glitch_sta2", reg_sta_do, 32'h0000_0101);

      // Reset mid-frame with one byte still queued
      ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b1, 1'b0);
      ps2_bit(1'b1, 1'b0);
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
      ps2_data = 1'b1;
      tick(2);
      check("mr_sta", reg_sta_do, 32'h0000_0000);
      check("mr_dat", reg_dat_do, 32'hFFFF_FFFF);
      check("mr_irq", 32'(irq), 32'h0);
      tick(20);
      send_good(8'h3C);
      check("mr_next_sta", reg_sta_do, 32'h0000_0101);
      pop_check("mr_next_dat", 32'h0000_003C);
      check("mr_final", reg_sta_do, 32'h0000_0000);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
